gate_response_misr: RTL

- Downstream response compactor for the 13-input/10-output combinational gate models in the gate library.
- Consumes the 10 model outputs once per applied test pattern and folds them into a 10-bit multiple-input signature register (MISR).
- After a programmed number of patterns it stops, holds the signature, and flags pass/fail against a golden value.
- Lets a lab bench check a whole gate model with a single compare instead of per-pattern checks.

---
 rtl/gate_test_pkg.sv | 29 ++
 rtl/misr_core.sv | 41 ++++
 rtl/gate_response_misr.sv | 103 ++++++++++
 3 files changed

// File: rtl/gate_test_pkg.sv
// Shared types and helpers for the gate-model test path: response FSM states,
// gate model port widths and the MISR/LFSR shift step.
package gate_test_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_e;

  localparam int GATE_OUT_W = 10;
  localparam int GATE_IN_W  = 13;

  // x^10 + x^3 + 1
  localparam logic [GATE_OUT_W-1:0] POLY_10 = 10'h009;

  // Galois-form shift with feedback, then XOR of the parallel input.
  // With din == 0 this is the plain LFSR step used by the pattern generator.
  function automatic logic [GATE_OUT_W-1:0] misr_step(
    input logic [GATE_OUT_W-1:0] sig,
    input logic [GATE_OUT_W-1:0] poly,
    input logic [GATE_OUT_W-1:0] din
  );
    logic [GATE_OUT_W-1:0] fb;
    fb = sig[GATE_OUT_W-1] ? poly : '0;
    return ({sig[GATE_OUT_W-2:0], 1'b0} ^ fb) ^ din;
  endfunction

endpackage

// File: rtl/misr_core.sv
// W-bit multiple-input signature register: reseeds on load_seed, folds in one
// response word per shift_en.
module misr_core
  import gate_test_pkg::*;
#(
  parameter int             W    = GATE_OUT_W,
  parameter logic [W-1:0]   POLY = POLY_10,
  parameter logic [W-1:0]   SEED = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_seed,
  input  logic         shift_en,
  input  logic [W-1:0] resp,
  output logic [W-1:0] sig
);

  logic [W-1:0] r_sig;
  logic [W-1:0] w_next;

  generate
    if (W == GATE_OUT_W) begin : g_pkg_step
      assign w_next = misr_step(r_sig, POLY, resp);
    end else begin : g_generic_step
      assign w_next = ({r_sig[W-2:0], 1'b0} ^ (r_sig[W-1] ? POLY : '0)) ^ resp;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sig <= SEED;
    end else if (load_seed) begin
      r_sig <= SEED;
    end else if (shift_en) begin
      r_sig <= w_next;
    end
  end

  assign sig = r_sig;

endmodule

// File: rtl/gate_response_misr.sv
// Response compactor for the gate models: folds a programmed number of
// 10-bit responses into a MISR, then freezes and compares against golden.
module gate_response_misr
  import gate_test_pkg::*;
#(
  parameter int           W    = GATE_OUT_W,
  parameter logic [W-1:0] POLY = POLY_10,
  parameter logic [W-1:0] SEED = '0,
  parameter int           CW   = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [CW-1:0] n_patterns,
  input  logic [W-1:0]  resp,
  input  logic          resp_valid,
  input  logic [W-1:0]  golden,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [W-1:0]  signature,
  output logic [CW-1:0] count
);

  state_e        r_state;
  logic [CW-1:0] r_target;
  logic [CW-1:0] r_count;
  logic          r_busy;
  logic          r_done;

  logic          w_accept_start;
  logic          w_shift;
  logic [CW-1:0] w_count_inc;
  logic [W-1:0]  w_sig;

  // start is honoured only outside CAPTURE; samples only inside it
  assign w_accept_start = start && (r_state != CAPTURE);
  assign w_shift        = resp_valid && (r_state == CAPTURE);
  assign w_count_inc    = r_count + 1'b1;

  misr_core #(
    .W    (W),
    .POLY (POLY),
    .SEED (SEED)
  ) u_misr (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_seed (w_accept_start),
    .shift_en  (w_shift),
    .resp      (resp),
    .sig       (w_sig)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_target <= '0;
      r_count  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_target <= n_patterns;
            r_count  <= '0;
            if (n_patterns == '0) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= CAPTURE;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
            end
          end
        end
        CAPTURE: begin
          if (resp_valid) begin
            r_count <= w_count_inc;
            if (w_count_inc == r_target) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign signature = w_sig;
  assign count     = r_count;
  assign pass      = r_done && (w_sig == golden);

endmodule
